phy_rx_deframer: RTL and testbench

Receive-side counterpart of the transmit PHY framer. It samples the 4-bit MII-style nibble stream (`phy_data_in`, `phy_rx_dv`) in the PHY clock domain and strips and checks the preamble/SFD. It reassembles payload nibbles into bytes, and at end of frame emits a 24-bit control block with byte count, priority and error status. Its output byte/control interface mirrors the transmitter's input side (data, data-valid, frame-valid, control block, priority), so it can feed a receive buffer directly.

---
 rtl/phy_rx_if.sv | 31 +++
 rtl/phy_rx_deframer.sv | 165 ++++++++++++++++
 tb/tb_phy_rx_deframer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/phy_rx_if.sv
// Receive-side bus of the PHY deframer: nibble stream in, byte strobe and frame report out.
// The slave modport is the deframer's view; master is the driving PHY/consumer side.
interface phy_rx_if;
    logic [3:0]  phy_data_in;
    logic        phy_rx_dv;
    logic [7:0]  r_data_out;
    logic        r_data_valid;
    logic        r_frame_valid;
    logic [23:0] r_ctrl_out;
    logic        r_hi_priority;

    modport master (
        output phy_data_in,
        output phy_rx_dv,
        input  r_data_out,
        input  r_data_valid,
        input  r_frame_valid,
        input  r_ctrl_out,
        input  r_hi_priority
    );

    modport slave (
        input  phy_data_in,
        input  phy_rx_dv,
        output r_data_out,
        output r_data_valid,
        output r_frame_valid,
        output r_ctrl_out,
        output r_hi_priority
    );
endinterface

// File: rtl/phy_rx_deframer.sv
// MII-style receive deframer: checks preamble/SFD, packs nibbles into bytes and
// reports byte count, priority and error flags at end of frame.
module phy_rx_deframer #(
    parameter int unsigned MIN_PRE = 7,
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 2047
) (
    input logic     clk_phy,
    input logic     reset_n,
    phy_rx_if.slave rx
);

    localparam logic [3:0]  PreMin   = 4'(MIN_PRE);
    localparam logic [11:0] LenMin   = 12'(MIN_LEN);
    localparam logic [11:0] LenMax   = 12'(MAX_LEN);
    localparam logic [3:0]  NibPre   = 4'h5;
    localparam logic [3:0]  NibSfd   = 4'hD;
    localparam logic [3:0]  NibSfdHi = 4'hF;

    typedef enum logic [1:0] {StIdle, StPreamble, StData, StDrop} state_e;

    state_e      state_q, state_d;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic        phase_q, phase_d;
    logic [3:0]  low_q, low_d;
    logic [11:0] byte_cnt_q, byte_cnt_d;
    logic        hi_pri_q, hi_pri_d;
    logic        oversize_q, oversize_d;
    logic        report_q, report_d;
    logic [7:0]  data_q, data_d;
    logic        data_valid_q, data_valid_d;
    logic        frame_valid_q, frame_valid_d;
    logic [23:0] ctrl_q, ctrl_d;
    logic        hi_out_q, hi_out_d;
    logic        emit;

    always_comb begin
        state_d       = state_q;
        pre_cnt_d     = pre_cnt_q;
        phase_d       = phase_q;
        low_d         = low_q;
        byte_cnt_d    = byte_cnt_q;
        hi_pri_d      = hi_pri_q;
        oversize_d    = oversize_q;
        report_d      = report_q;
        data_d        = data_q;
        data_valid_d  = 1'b0;
        frame_valid_d = 1'b0;
        ctrl_d        = ctrl_q;
        hi_out_d      = hi_out_q;
        emit          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx.phy_rx_dv) begin
                    if (rx.phy_data_in == NibPre) begin
                        state_d   = StPreamble;
                        pre_cnt_d = 4'd1;
                    end else begin
                        state_d  = StDrop;
                        report_d = 1'b0;
                    end
                end
            end
            StPreamble: begin
                if (!rx.phy_rx_dv) begin
                    state_d = StIdle;
                end else if (rx.phy_data_in == NibPre) begin
                    if (pre_cnt_q != 4'hF) begin
                        pre_cnt_d = pre_cnt_q + 4'd1;
                    end
                end else if ((rx.phy_data_in == NibSfd || rx.phy_data_in == NibSfdHi) &&
                             pre_cnt_q >= PreMin) begin
                    state_d    = StData;
                    hi_pri_d   = (rx.phy_data_in == NibSfdHi);
                    byte_cnt_d = 12'd0;
                    oversize_d = 1'b0;
                    phase_d    = 1'b0;
                end else begin
                    state_d  = StDrop;
                    report_d = 1'b0;
                end
            end
            StData: begin
                if (!rx.phy_rx_dv) begin
                    emit = 1'b1;
                end else if (!phase_q) begin
                    low_d   = rx.phy_data_in;
                    phase_d = 1'b1;
                end else begin
                    phase_d      = 1'b0;
                    data_d       = {rx.phy_data_in, low_q};
                    data_valid_d = 1'b1;
                    byte_cnt_d   = byte_cnt_q + 12'd1;
                    // Count is capped here; the rest of the frame is swallowed.
                    if (byte_cnt_q + 12'd1 == LenMax) begin
                        oversize_d = 1'b1;
                        state_d    = StDrop;
                        report_d   = 1'b1;
                    end
                end
            end
            StDrop: begin
                if (!rx.phy_rx_dv) begin
                    if (report_q) begin
                        emit = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A dangling low nibble (phase set) marks misalignment and is dropped.
        if (emit) begin
            ctrl_d        = {byte_cnt_q, 8'h00, hi_pri_q, phase_q, (byte_cnt_q < LenMin),
                             oversize_q};
            hi_out_d      = hi_pri_q;
            frame_valid_d = 1'b1;
            state_d       = StIdle;
            phase_d       = 1'b0;
            report_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_phy) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            pre_cnt_q     <= 4'd0;
            phase_q       <= 1'b0;
            low_q         <= 4'd0;
            byte_cnt_q    <= 12'd0;
            hi_pri_q      <= 1'b0;
            oversize_q    <= 1'b0;
            report_q      <= 1'b0;
            data_q        <= 8'h00;
            data_valid_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            ctrl_q        <= 24'h000000;
            hi_out_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pre_cnt_q     <= pre_cnt_d;
            phase_q       <= phase_d;
            low_q         <= low_d;
            byte_cnt_q    <= byte_cnt_d;
            hi_pri_q      <= hi_pri_d;
            oversize_q    <= oversize_d;
            report_q      <= report_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            frame_valid_q <= frame_valid_d;
            ctrl_q        <= ctrl_d;
            hi_out_q      <= hi_out_d;
        end
    end

    assign rx.r_data_out    = data_q;
    assign rx.r_data_valid  = data_valid_q;
    assign rx.r_frame_valid = frame_valid_q;
    assign rx.r_ctrl_out    = ctrl_q;
    assign rx.r_hi_priority = hi_out_q;

endmodule

// File: tb/tb_phy_rx_deframer.sv
// Bench for phy_rx_deframer: two instances (default MAX_LEN and MAX_LEN=100) share one
// nibble stream; observed strobes are compared with a frame-level reference model.
module tb_phy_rx_deframer;

    localparam int MinPre = 7;
    localparam int MinLen = 64;
    localparam int MaxA   = 2047;
    localparam int MaxB   = 100;

    typedef logic [3:0]  nib_t;
    typedef nib_t        nib_q_t[$];
    typedef logic [7:0]  byte_q_t[$];
    typedef logic [23:0] ctrl_q_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    nib_t nib = 4'h0;
    logic dv = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    byte_q_t obs_a_b, obs_b_b, exp_a_b, exp_b_b;
    ctrl_q_t obs_a_c, obs_b_c, exp_a_c, exp_b_c;
    logic    obs_a_h[$];
    logic    obs_b_h[$];

    phy_rx_if ifa ();
    phy_rx_if ifb ();

    assign ifa.phy_data_in = nib;
    assign ifa.phy_rx_dv   = dv;
    assign ifb.phy_data_in = nib;
    assign ifb.phy_rx_dv   = dv;

    phy_rx_deframer u_dut_a (
        .clk_phy (clk),
        .reset_n (rst_n),
        .rx      (ifa)
    );

    phy_rx_deframer #(.MAX_LEN(MaxB)) u_dut_b (
        .clk_phy (clk),
        .reset_n (rst_n),
        .rx      (ifb)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ifa.r_data_valid === 1'b1) obs_a_b.push_back(ifa.r_data_out);
        if (ifb.r_data_valid === 1'b1) obs_b_b.push_back(ifb.r_data_out);
        if (ifa.r_frame_valid === 1'b1) begin
            obs_a_c.push_back(ifa.r_ctrl_out);
            obs_a_h.push_back(ifa.r_hi_priority);
        end
        if (ifb.r_frame_valid === 1'b1) begin
            obs_b_c.push_back(ifb.r_ctrl_out);
            obs_b_h.push_back(ifb.r_hi_priority);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_all();
        obs_a_b.delete(); obs_b_b.delete(); exp_a_b.delete(); exp_b_b.delete();
        obs_a_c.delete(); obs_b_c.delete(); exp_a_c.delete(); exp_b_c.delete();
        obs_a_h.delete(); obs_b_h.delete();
    endtask

    task automatic mk_frame(input int npre, input nib_t sfd, input byte_q_t pay, input bit odd,
                            output nib_q_t f);
        f = {};
        for (int i = 0; i < npre; i++) f.push_back(4'h5);
        f.push_back(sfd);
        foreach (pay[i]) begin
            f.push_back(pay[i][3:0]);
            f.push_back(pay[i][7:4]);
        end
        if (odd) f.push_back(nib_t'($urandom_range(0, 15)));
    endtask

    task automatic rand_bytes(input int n, output byte_q_t q);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    endtask

    // Frame-level reference: parse preamble/SFD, pair nibbles, cap at the limit.
    task automatic model(input nib_q_t f);
        int n, pay, nb, odd, cnt, lim;
        bit hi, al, ru, ov;
        logic [7:0] b;
        n = 0;
        if (f.size() == 0 || f[0] !== 4'h5) return;
        while (n < f.size() && f[n] == 4'h5) n++;
        if (n == f.size()) return;
        if (n < MinPre || !(f[n] == 4'hD || f[n] == 4'hF)) return;
        hi  = (f[n] == 4'hF);
        pay = f.size() - n - 1;
        nb  = pay / 2;
        odd = pay % 2;
        for (int k = 0; k < 2; k++) begin
            lim = (k == 0) ? MaxA : MaxB;
            ov  = (nb >= lim);
            cnt = ov ? lim : nb;
            al  = !ov && (odd != 0);
            ru  = (cnt < MinLen);
            for (int i = 0; i < cnt; i++) begin
                b = {f[n + 2 + 2 * i], f[n + 1 + 2 * i]};
                if (k == 0) exp_a_b.push_back(b); else exp_b_b.push_back(b);
            end
            if (k == 0) exp_a_c.push_back({12'(cnt), 8'h00, hi, al, ru, ov});
            else        exp_b_c.push_back({12'(cnt), 8'h00, hi, al, ru, ov});
        end
    endtask

    task automatic drive(input nib_q_t f, input int gap);
        foreach (f[i]) begin
            @(negedge clk);
            dv  = 1'b1;
            nib = f[i];
        end
        @(negedge clk);
        dv  = 1'b0;
        nib = 4'h0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic settle();
        repeat (5) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dv    = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (ifa.r_data_out !== 8'h00) begin n_err++;
            $display("FAIL reset_data_out got %h want 00", ifa.r_data_out); end
        n_cmp++; if (ifa.r_data_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_data_valid got %b want 0", ifa.r_data_valid); end
        n_cmp++; if (ifa.r_frame_valid !== 1'b0) begin n_err++;
            $display("FAIL reset_frame_valid got %b want 0", ifa.r_frame_valid); end
        n_cmp++; if (ifa.r_ctrl_out !== 24'h0) begin n_err++;
            $display("FAIL reset_ctrl got %h want 000000", ifa.r_ctrl_out); end
        n_cmp++; if (ifa.r_hi_priority !== 1'b0) begin n_err++;
            $display("FAIL reset_hi_pri got %b want 0", ifa.r_hi_priority); end
        n_cmp++;
        if ({ifb.r_data_out, ifb.r_data_valid, ifb.r_frame_valid, ifb.r_ctrl_out,
             ifb.r_hi_priority} !== 35'd0) begin n_err++;
            $display("FAIL reset_b_outputs got %h want 0", {ifb.r_data_out, ifb.r_ctrl_out});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_min_frame();
        byte_q_t p;
        nib_q_t  f;
        clear_all();
        for (int i = 0; i < 64; i++) p.push_back(8'(i));
        mk_frame(7, 4'hD, p, 1'b0, f);
        model(f);
        drive(f, 1);
        settle();
        n_cmp++; if (obs_a_b.size() != 64) begin n_err++;
            $display("FAIL min_nbytes got %0d want 64", obs_a_b.size()); end
        foreach (obs_a_b[i]) if (i < 64) begin
            n_cmp++; if (obs_a_b[i] !== 8'(i)) begin n_err++;
                $display("FAIL min_byte[%0d] got %h want %h", i, obs_a_b[i], 8'(i)); end
        end
        n_cmp++; if (obs_a_c.size() != 1) begin n_err++;
            $display("FAIL min_nreports got %0d want 1", obs_a_c.size()); end
        else begin
            n_cmp++; if (obs_a_c[0] !== 24'h040000) begin n_err++;
                $display("FAIL min_ctrl got %h want 040000", obs_a_c[0]); end
            n_cmp++; if (obs_a_h[0] !== 1'b0) begin n_err++;
                $display("FAIL min_hi_pri got %b want 0", obs_a_h[0]); end
        end
    endtask

    task automatic test_hi_priority();
        byte_q_t p;
        nib_q_t  f;
        clear_all();
        for (int i = 0; i < 512; i++) p.push_back(8'hA5);
        mk_frame(7, 4'hF, p, 1'b0, f);
        drive(f, 1);
        settle();
        n_cmp++; if (obs_a_b.size() != 512) begin n_err++;
            $display("FAIL hi_nbytes got %0d want 512", obs_a_b.size()); end
        n_cmp++; if (obs_a_c.size() != 1) begin n_err++;
            $display("FAIL hi_nreports got %0d want 1", obs_a_c.size()); end
        else begin
            n_cmp++; if (obs_a_c[0] !== 24'h200008) begin n_err++;
                $display("FAIL hi_ctrl got %h want 200008", obs_a_c[0]); end
            n_cmp++; if (obs_a_h[0] !== 1'b1) begin n_err++;
                $display("FAIL hi_hi_pri got %b want 1", obs_a_h[0]); end
        end
    endtask

    task automatic test_runt();
        byte_q_t p;
        nib_q_t  f;
        clear_all();
        rand_bytes(10, p);
        mk_frame(8, 4'hD, p, 1'b1, f);
        model(f);
        drive(f, 1);
        settle();
        n_cmp++; if (obs_a_b.size() != 10) begin n_err++;
            $display("FAIL runt_nbytes got %0d want 10", obs_a_b.size()); end
        foreach (obs_a_b[i]) if (i < p.size()) begin
            n_cmp++; if (obs_a_b[i] !== p[i]) begin n_err++;
                $display("FAIL runt_byte[%0d] got %h want %h", i, obs_a_b[i], p[i]); end
        end
        n_cmp++; if (obs_a_c.size() != 1) begin n_err++;
            $display("FAIL runt_nreports got %0d want 1", obs_a_c.size()); end
        else begin
            n_cmp++; if (obs_a_c[0] !== 24'h00A006) begin n_err++;
                $display("FAIL runt_ctrl got %h want 00A006", obs_a_c[0]); end
        end
    endtask

    task automatic test_oversize();
        byte_q_t p;
        nib_q_t  f;
        clear_all();
        rand_bytes(150, p);
        mk_frame(7, 4'hD, p, 1'b0, f);
        drive(f, 1);
        settle();
        n_cmp++; if (obs_b_b.size() != 100) begin n_err++;
            $display("FAIL ovs_b_nbytes got %0d want 100", obs_b_b.size()); end
        foreach (obs_b_b[i]) if (i < p.size()) begin
            n_cmp++; if (obs_b_b[i] !== p[i]) begin n_err++;
                $display("FAIL ovs_b_byte[%0d] got %h want %h", i, obs_b_b[i], p[i]); end
        end
        n_cmp++; if (obs_b_c.size() != 1) begin n_err++;
            $display("FAIL ovs_b_nreports got %0d want 1", obs_b_c.size()); end
        else begin
            n_cmp++; if (obs_b_c[0] !== 24'h064001) begin n_err++;
                $display("FAIL ovs_b_ctrl got %h want 064001", obs_b_c[0]); end
        end
        n_cmp++; if (obs_a_b.size() != 150) begin n_err++;
            $display("FAIL ovs_a_nbytes got %0d want 150", obs_a_b.size()); end
        n_cmp++; if (obs_a_c.size() != 1 || obs_a_c[0] !== 24'h096000) begin n_err++;
            $display("FAIL ovs_a_ctrl got %0d reports want one of 096000", obs_a_c.size()); end
    endtask

    task automatic test_bad_preamble();
        byte_q_t p;
        nib_q_t  f1, f2, f3;
        clear_all();
        rand_bytes(20, p);
        mk_frame(5, 4'hD, p, 1'b0, f1);
        mk_frame(7, 4'hD, p, 1'b0, f2);
        f2[3] = 4'h7;
        rand_bytes(70, p);
        mk_frame(7, 4'hD, p, 1'b0, f3);
        model(f3);
        drive(f1, 1);
        drive(f2, 1);
        drive(f3, 1);
        settle();
        n_cmp++; if (obs_a_b.size() != exp_a_b.size()) begin n_err++;
            $display("FAIL badpre_nbytes got %0d want %0d", obs_a_b.size(), exp_a_b.size()); end
        foreach (obs_a_b[i]) if (i < exp_a_b.size()) begin
            n_cmp++; if (obs_a_b[i] !== exp_a_b[i]) begin n_err++;
                $display("FAIL badpre_byte[%0d] got %h want %h", i, obs_a_b[i], exp_a_b[i]); end
        end
        n_cmp++; if (obs_a_c.size() != 1) begin n_err++;
            $display("FAIL badpre_nreports got %0d want 1", obs_a_c.size()); end
        else begin
            n_cmp++; if (obs_a_c[0] !== exp_a_c[0]) begin n_err++;
                $display("FAIL badpre_ctrl got %h want %h", obs_a_c[0], exp_a_c[0]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        byte_q_t p, p2;
        nib_q_t  f, f2;
        clear_all();
        rand_bytes(40, p);
        mk_frame(7, 4'hD, p, 1'b0, f);
        for (int i = 0; i < 68; i++) begin
            @(negedge clk);
            dv  = 1'b1;
            nib = f[i];
        end
        @(negedge clk);
        rst_n = 1'b0;
        dv    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({ifa.r_data_out, ifa.r_data_valid, ifa.r_frame_valid, ifa.r_ctrl_out,
             ifa.r_hi_priority} !== 35'd0) begin n_err++;
            $display("FAIL midrst_outputs got data %h ctrl %h want all 0",
                     ifa.r_data_out, ifa.r_ctrl_out);
        end
        for (int i = 0; i < 30; i++) exp_a_b.push_back(p[i]);
        rand_bytes(80, p2);
        mk_frame(9, 4'hD, p2, 1'b0, f2);
        model(f2);
        settle();
        drive(f2, 1);
        settle();
        n_cmp++; if (obs_a_b.size() != exp_a_b.size()) begin n_err++;
            $display("FAIL midrst_nbytes got %0d want %0d", obs_a_b.size(), exp_a_b.size()); end
        foreach (obs_a_b[i]) if (i < exp_a_b.size()) begin
            n_cmp++; if (obs_a_b[i] !== exp_a_b[i]) begin n_err++;
                $display("FAIL midrst_byte[%0d] got %h want %h", i, obs_a_b[i], exp_a_b[i]); end
        end
        n_cmp++; if (obs_a_c.size() != 1) begin n_err++;
            $display("FAIL midrst_nreports got %0d want 1", obs_a_c.size()); end
        else begin
            n_cmp++; if (obs_a_c[0] !== 24'h050000) begin n_err++;
                $display("FAIL midrst_ctrl got %h want 050000", obs_a_c[0]); end
        end
    endtask

    task automatic test_back_to_back();
        byte_q_t p;
        nib_q_t  f;
        nib_t    sfds[5];
        sfds = '{4'hD, 4'hF, 4'hD, 4'hF, 4'hB};
        clear_all();
        for (int k = 0; k < 8; k++) begin
            rand_bytes($urandom_range(0, 130), p);
            mk_frame($urandom_range(4, 10), sfds[$urandom_range(0, 4)], p,
                     1'($urandom_range(0, 1)), f);
            model(f);
            drive(f, 1);
        end
        settle();
        n_cmp++; if (obs_a_b.size() != exp_a_b.size()) begin n_err++;
            $display("FAIL b2b_a_nbytes got %0d want %0d", obs_a_b.size(), exp_a_b.size()); end
        foreach (obs_a_b[i]) if (i < exp_a_b.size()) begin
            n_cmp++; if (obs_a_b[i] !== exp_a_b[i]) begin n_err++;
                $display("FAIL b2b_a_byte[%0d] got %h want %h", i, obs_a_b[i], exp_a_b[i]); end
        end
        n_cmp++; if (obs_a_c.size() != exp_a_c.size()) begin n_err++;
            $display("FAIL b2b_a_nreports got %0d want %0d", obs_a_c.size(), exp_a_c.size()); end
        foreach (obs_a_c[i]) if (i < exp_a_c.size()) begin
            n_cmp++; if (obs_a_c[i] !== exp_a_c[i] || obs_a_h[i] !== exp_a_c[i][3]) begin
                n_err++;
                $display("FAIL b2b_a_ctrl[%0d] got %h/%b want %h", i, obs_a_c[i], obs_a_h[i],
                         exp_a_c[i]);
            end
        end
        n_cmp++; if (obs_b_b.size() != exp_b_b.size()) begin n_err++;
            $display("FAIL b2b_b_nbytes got %0d want %0d", obs_b_b.size(), exp_b_b.size()); end
        foreach (obs_b_b[i]) if (i < exp_b_b.size()) begin
            n_cmp++; if (obs_b_b[i] !== exp_b_b[i]) begin n_err++;
                $display("FAIL b2b_b_byte[%0d] got %h want %h", i, obs_b_b[i], exp_b_b[i]); end
        end
        n_cmp++; if (obs_b_c.size() != exp_b_c.size()) begin n_err++;
            $display("FAIL b2b_b_nreports got %0d want %0d", obs_b_c.size(), exp_b_c.size()); end
        foreach (obs_b_c[i]) if (i < exp_b_c.size()) begin
            n_cmp++; if (obs_b_c[i] !== exp_b_c[i] || obs_b_h[i] !== exp_b_c[i][3]) begin
                n_err++;
                $display("FAIL b2b_b_ctrl[%0d] got %h/%b want %h", i, obs_b_c[i], obs_b_h[i],
                         exp_b_c[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_min_frame();
        test_hi_priority();
        test_runt();
        test_oversize();
        test_bad_preamble();
        test_reset_mid_frame();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
